// File: rtl/argmax_classifier_if.sv
// argmax_classifier_if: read-port bus between the classifier (master) and the score BRAM (slave).
// Signals: ce_input/we_input/addr_input/din_input driven by master, qout_input driven by slave.
interface argmax_classifier_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  ce_input;
  logic                  we_input;
  logic [ADDR_WIDTH-1:0] addr_input;
  logic [DATA_WIDTH-1:0] din_input;
  logic [DATA_WIDTH-1:0] qout_input;
  modport master (output ce_input, we_input, addr_input, din_input, input qout_input);
  modport slave (input ce_input, we_input, addr_input, din_input, output qout_input);
endinterface

// File: rtl/argmax_classifier.sv
// argmax_classifier: reads NUM_CLASSES signed scores from BRAM and returns the index of the largest.
// Ports: clk, reset (sync, active-high), i_run (start pulse, sampled in IDLE),
//   bram (BRAM read port, master side), o_class (winning index), o_busy (READ/DRAIN),
//   layer_done (one-cycle pulse when o_class is final).
// Optional: ARGMAX_SCORE_OUT_EN adds o_max_score, the signed winning score.
module argmax_classifier #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CLASSES = 10,
  localparam int CLASS_W = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  argmax_classifier_if.master bram,
  output logic [CLASS_W-1:0] o_class,
  output logic               o_busy,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [DATA_WIDTH-1:0] o_max_score,
`endif
  output logic               layer_done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM_CLASSES - 1);
  state_t state_q, state_d;
  logic [CLASS_W-1:0] rd_cnt_q, rd_cnt_d, data_idx_q, max_idx_q, max_idx_d, o_class_q;
  logic signed [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic valid_q, upd;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_WIDTH-1:0] o_max_score_q;
  assign o_max_score = o_max_score_q;
`endif
  always_comb begin
    state_d = state_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: if (i_run) begin
        state_d = READ;
        rd_cnt_d = '0;
      end
      READ: if (rd_cnt_q == LAST) state_d = DRAIN;
            else rd_cnt_d = rd_cnt_q + CLASS_W'(1);
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Index 0 loads unconditionally so a new run never inherits the previous maximum;
  // strict > keeps the lowest index on ties.
  always_comb begin
    upd = valid_q && (data_idx_q == '0 || $signed(bram.qout_input) > max_val_q);
    max_val_d = upd ? $signed(bram.qout_input) : max_val_q;
    max_idx_d = upd ? data_idx_q : max_idx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_cnt_q <= '0;
      data_idx_q <= '0;
      valid_q <= 1'b0;
      max_val_q <= '0;
      max_idx_q <= '0;
      o_class_q <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      o_max_score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rd_cnt_q <= rd_cnt_d;
      data_idx_q <= rd_cnt_q;
      valid_q <= state_q == READ;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      // The last word is compared on the same edge that enters DONE, so capture the next-state value.
      if (state_d == DONE) begin
        o_class_q <= max_idx_d;
`ifdef ARGMAX_SCORE_OUT_EN
        o_max_score_q <= max_val_d;
`endif
      end
    end
  end
  assign bram.ce_input = state_q == READ;
  assign bram.we_input = 1'b0;
  assign bram.addr_input = (state_q == READ) ? ADDR_WIDTH'(rd_cnt_q) : '0;
  assign bram.din_input = '0;
  assign o_class = o_class_q;
  assign o_busy = state_q == READ || state_q == DRAIN;
  assign layer_done = state_q == DONE;
endmodule
